// File: rtl/alu_sel_pkg.sv
// Shared definitions for the ALU result selector: select-mode encoding.
package alu_sel_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } sel_mode_e;

endpackage

// File: rtl/alu_result_sel_reg_nway_mux.sv
// Combinational N:1 selector over a packed channel vector; out-of-range
// selects return zero and raise err.
module nway_mux #(
  parameter int W   = 32,
  parameter int NCH = 8,
  parameter int SW  = 3
) (
  input  logic [NCH*W-1:0] data_in,
  input  logic [SW-1:0]    sel,
  output logic [W-1:0]     data_o,
  output logic             err
);

  localparam int unsigned NCHU  = NCH;
  localparam logic [SW:0] NCH_L = NCHU[SW:0];

  // Extra MSB so NCH == 2**SW still compares correctly.
  assign err = ({1'b0, sel} >= NCH_L);

  always_comb begin
    data_o = '0;
    for (int k = 0; k < NCH; k++) begin
      if (sel == k[SW-1:0]) data_o = data_in[k*W +: W];
    end
  end

endmodule

// File: rtl/alu_result_sel_reg.sv
// Registered N:1 ALU result selector with valid/ready output stage and an
// auto-incrementing channel-scan mode.
module alu_result_sel_reg
  import alu_sel_pkg::*;
#(
  parameter int W   = 32,
  parameter int NCH = 8,
  parameter int SW  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NCH*W-1:0] data_in,
  input  logic [SW-1:0]    sel,
  input  logic             mode,
  input  logic             scan_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     data_out,
  output logic [SW-1:0]    ch_out,
  output logic             sel_err,
  output logic             scan_wrap
);

  localparam int unsigned LASTI = NCH - 1;
  localparam logic [SW-1:0] LAST = LASTI[SW-1:0];

  logic          vld_q, vld_d;
  logic [W-1:0]  data_q, data_d;
  logic [SW-1:0] ch_q, ch_d;
  logic          err_q, err_d;
  logic          wrap_q, wrap_d;
  logic [SW-1:0] cnt_q, cnt_d;

  logic          accept;
  logic          scan;
  logic [SW-1:0] eff;
  logic [W-1:0]  mux_data;
  logic          mux_err;

  assign in_ready = !vld_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign scan     = (mode == MODE_SCAN);
  assign eff      = scan ? cnt_q : sel;

  nway_mux #(.W(W), .NCH(NCH), .SW(SW)) u_mux (
    .data_in (data_in),
    .sel     (eff),
    .data_o  (mux_data),
    .err     (mux_err)
  );

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    ch_d   = ch_q;
    err_d  = err_q;
    wrap_d = wrap_q;
    if (accept) begin
      vld_d  = 1'b1;
      data_d = mux_data;
      ch_d   = eff;
      err_d  = mux_err;
      wrap_d = scan && (cnt_q == LAST);
    end else if (vld_q && out_ready) begin
      vld_d  = 1'b0;
    end
  end

  // Clear wins over increment; the accept above already used the old count.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && scan) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    if (scan_clr)       cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      ch_q   <= '0;
      err_q  <= 1'b0;
      wrap_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      ch_q   <= ch_d;
      err_q  <= err_d;
      wrap_q <= wrap_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_valid = vld_q;
  assign data_out  = data_q;
  assign ch_out    = ch_q;
  assign sel_err   = err_q;
  assign scan_wrap = wrap_q;

endmodule
